// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS phase accumulator and its optional dither LFSR.
package dds_pkg;

  localparam logic [1:0] CFG_FTW    = 2'b00;
  localparam logic [1:0] CFG_POFF   = 2'b01;
  localparam logic [1:0] CFG_RSVD   = 2'b10;
  localparam logic [1:0] CFG_COMMIT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } dds_state_e;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic int dither_width(input int acc_w, input int phase_w);
    int w;
    w = acc_w - phase_w;
    if (w > 16) w = 16;
    if (w < 0)  w = 0;
    return w;
  endfunction

endpackage

// File: rtl/dds_dither_lfsr.sv
// 16-bit Fibonacci LFSR used to dither the truncated DDS phase; advances only while enabled.
module dds_dither_lfsr
  import dds_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        adv_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  always_comb begin
    fb     = ^(lfsr_q & LFSR_TAPS);
    lfsr_d = lfsr_q;
    if (adv_i) lfsr_d = {fb, lfsr_q[15:1]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/dds_phase_accum.sv
// DDS phase accumulator with shadowed FTW/phase-offset config and immediate or at-wrap commit.
// Optional phase dither is enabled by defining DDS_PHASE_DITHER_EN.
module dds_phase_accum
  import dds_pkg::*;
#(
  parameter int ACC_W   = 32,
  parameter int PHASE_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [1:0]         cfg_sel_i,
  input  logic [ACC_W-1:0]   cfg_data_i,
  input  logic               run_i,
  output logic [PHASE_W-1:0] phase_out_o,
  output logic               phase_vld_o,
  output logic               wrap_o,
  output logic               pending_o
);

  dds_state_e         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   ftw_act_q, ftw_act_d;
  logic [ACC_W-1:0]   poff_act_q, poff_act_d;
  logic [ACC_W-1:0]   ftw_sh_q, ftw_sh_d;
  logic [ACC_W-1:0]   poff_sh_q, poff_sh_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               vld_q, wrap_q;

  logic [ACC_W:0]     acc_sum;
  logic [ACC_W-1:0]   phase_full;
  logic               carry;
  logic               cfg_xfer;

  assign acc_sum  = {1'b0, acc_q} + {1'b0, ftw_act_q};
  assign carry    = run_i & acc_sum[ACC_W];
  assign cfg_xfer = cfg_valid_i & cfg_ready_o;

`ifdef DDS_PHASE_DITHER_EN
  localparam int          DITH_W    = dither_width(ACC_W, PHASE_W);
  localparam logic [15:0] DITH_MASK = (DITH_W >= 16) ? 16'hFFFF : 16'((32'd1 << DITH_W) - 32'd1);
  logic [15:0] lfsr;

  dds_dither_lfsr u_dither (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .adv_i  (run_i),
    .lfsr_o (lfsr)
  );

  // Carry out of the dither add is dropped; wrap only follows the accumulator.
  assign phase_full = acc_q + poff_act_q + ACC_W'(lfsr & DITH_MASK);
`else
  assign phase_full = acc_q + poff_act_q;
`endif

  assign phase_d = phase_full[ACC_W-1 -: PHASE_W];

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    ftw_act_d  = ftw_act_q;
    poff_act_d = poff_act_q;
    ftw_sh_d   = ftw_sh_q;
    poff_sh_d  = poff_sh_q;

    if (run_i) acc_d = acc_sum[ACC_W-1:0];

    unique case (state_q)
      ST_IDLE: if (run_i)  state_d = ST_RUN;
      ST_RUN:  if (!run_i) state_d = ST_IDLE;
      ST_PEND: begin
        if (carry) begin
          ftw_act_d  = ftw_sh_q;
          poff_act_d = poff_sh_q;
          state_d    = run_i ? ST_RUN : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // No transfer can be accepted in ST_PEND, so this never races the wrap copy above.
    if (cfg_xfer) begin
      case (cfg_sel_i)
        CFG_FTW:  ftw_sh_d  = cfg_data_i;
        CFG_POFF: poff_sh_d = cfg_data_i;
        CFG_COMMIT: begin
          if (cfg_data_i[0]) begin
            ftw_act_d  = ftw_sh_q;
            poff_act_d = poff_sh_q;
          end else begin
            state_d = ST_PEND;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      ftw_act_q  <= '0;
      poff_act_q <= '0;
      ftw_sh_q   <= '0;
      poff_sh_q  <= '0;
      phase_q    <= '0;
      vld_q      <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      ftw_act_q  <= ftw_act_d;
      poff_act_q <= poff_act_d;
      ftw_sh_q   <= ftw_sh_d;
      poff_sh_q  <= poff_sh_d;
      phase_q    <= phase_d;
      vld_q      <= run_i;
      wrap_q     <= carry;
    end
  end

  assign cfg_ready_o = (state_q != ST_PEND);
  assign pending_o   = (state_q == ST_PEND);
  assign phase_out_o = phase_q;
  assign phase_vld_o = vld_q;
  assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_dds_phase_accum.sv
// Randomized and directed checks of dds_phase_accum against an arithmetic reference model.
module tb_dds_phase_accum;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_valid_i = 1'b0;
  logic        cfg_ready_o;
  logic [1:0]  cfg_sel_i = 2'b00;
  logic [31:0] cfg_data_i = '0;
  logic        run_i = 1'b0;
  logic [7:0]  phase_out_o;
  logic        phase_vld_o, wrap_o, pending_o;

  dds_phase_accum #(.ACC_W(32), .PHASE_W(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_sel_i   (cfg_sel_i),
    .cfg_data_i  (cfg_data_i),
    .run_i       (run_i),
    .phase_out_o (phase_out_o),
    .phase_vld_o (phase_vld_o),
    .wrap_o      (wrap_o),
    .pending_o   (pending_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: accumulator, active/shadow tuning words and the registered outputs.
  logic [31:0] m_acc, m_fa, m_pa, m_fs, m_ps;
  logic [7:0]  m_ph;
  bit          m_pend, m_vld, m_wrap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit carry_next();
    longint s;
    s = longint'(m_acc) + longint'(m_fa);
    return run_i && (s >= 64'h1_0000_0000);
  endfunction

  task automatic model_edge();
    longint      s;
    logic [31:0] p;
    bit          c;
    bit          take;
    logic [31:0] fs, ps;
    if (rst_i) begin
      m_acc = 0; m_fa = 0; m_pa = 0; m_fs = 0; m_ps = 0;
      m_ph = 0; m_pend = 0; m_vld = 0; m_wrap = 0;
    end else begin
      s    = longint'(m_acc) + longint'(m_fa);
      c    = run_i && (s >= 64'h1_0000_0000);
      take = cfg_valid_i && !m_pend;
      fs   = m_fs;
      ps   = m_ps;
      p    = m_acc + m_pa;
      m_ph   = p[31:24];
      m_vld  = run_i;
      m_wrap = c;
      if (run_i) m_acc = 32'(s);
      if (m_pend && c) begin
        m_fa = fs; m_pa = ps; m_pend = 0;
      end
      if (take) begin
        case (cfg_sel_i)
          2'b00: m_fs = cfg_data_i;
          2'b01: m_ps = cfg_data_i;
          2'b11: if (cfg_data_i[0]) begin m_fa = fs; m_pa = ps; end
                 else m_pend = 1;
          default: ;
        endcase
      end
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    chk("phase_out", 32'(phase_out_o), 32'(m_ph));
    chk("phase_vld", 32'(phase_vld_o), 32'(m_vld));
    chk("wrap",      32'(wrap_o),      32'(m_wrap));
    chk("pending",   32'(pending_o),   32'(m_pend));
    chk("cfg_ready", 32'(cfg_ready_o), 32'(!m_pend));
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [31:0] data);
    cfg_valid_i = 1'b1;
    cfg_sel_i   = sel;
    cfg_data_i  = data;
    step();
    cfg_valid_i = 1'b0;
  endtask

  task automatic wait_carry(input int budget);
    int n;
    n = 0;
    while (!carry_next() && n < budget) begin
      step();
      n++;
    end
    chk("carry_wait_timeout", 32'(n < budget), 32'd1);
  endtask

  initial begin
    int w;
    int r;
    // Reset state
    rst_i = 1'b1;
    step(); step();
    rst_i = 1'b0;
    chk("reset_ready", 32'(cfg_ready_o), 32'd1);
    chk("reset_phase", 32'(phase_out_o), 32'd0);

    // Ramp 0,1,2,... with one wrap per 256 clocks
    cfg(2'b00, 32'h0100_0000);
    cfg(2'b11, 32'h1);
    run_i = 1'b1;
    w = 0;
    for (int i = 0; i < 520; i++) begin
      step();
      if (wrap_o) w++;
    end
    chk("ramp_wrap_count", 32'(w), 32'd2);

    // Half-rate: 00/80 alternation
    cfg(2'b00, 32'h8000_0000);
    cfg(2'b11, 32'h1);
    for (int i = 0; i < 8; i++) step();

    // At-wrap commit of a new offset and FTW
    cfg(2'b01, 32'h4000_0000);
    cfg(2'b00, 32'h0100_0000);
    cfg(2'b11, 32'h0);
    chk("atwrap_pending", 32'(pending_o), 32'd1);
    for (int i = 0; i < 6; i++) step();
    chk("atwrap_cleared", 32'(pending_o), 32'd0);

    // At-wrap commit accepted on a carry cycle waits for the next carry
    cfg(2'b00, 32'h8000_0000);
    cfg(2'b11, 32'h1);
    cfg(2'b01, 32'h2000_0000);
    wait_carry(8);
    cfg(2'b11, 32'h0);
    chk("carry_cycle_wrap", 32'(wrap_o), 32'd1);
    chk("carry_cycle_pend", 32'(pending_o), 32'd1);
    for (int i = 0; i < 4; i++) step();

    // Pause and resume
    cfg(2'b00, 32'h0340_0000);
    cfg(2'b11, 32'h1);
    for (int i = 0; i < 5; i++) step();
    run_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    run_i = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Immediate commit while stopped, then at-wrap commit that waits while stopped
    run_i = 1'b0;
    cfg(2'b01, 32'h1234_5678);
    cfg(2'b11, 32'h1);
    step(); step();
    cfg(2'b00, 32'hC000_0000);
    cfg(2'b11, 32'h0);
    for (int i = 0; i < 10; i++) step();

    // Reset while pending drops the commit and clears the shadows
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rst_pend_phase", 32'(phase_out_o), 32'd0);
    chk("rst_pend_pending", 32'(pending_o), 32'd0);
    run_i = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst_i       = ($urandom_range(0, 299) == 0);
      run_i       = ($urandom_range(0, 7) != 0);
      cfg_valid_i = ($urandom_range(0, 3) == 0);
      cfg_sel_i   = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 3);
      case (r)
        0: cfg_data_i = $urandom;
        1: cfg_data_i = 32'h8000_0000;
        2: cfg_data_i = $urandom >> $urandom_range(1, 12);
        default: cfg_data_i = {$urandom, 1'b0} | 32'($urandom_range(0, 1));
      endcase
      step();
    end
    rst_i = 1'b0;
    cfg_valid_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
